iq_sigma_delta_tx: RTL
======================

IQ_SIGMA_DELTA_TX -- requirements
Module: iq_sigma_delta_tx

Interface
REQ-001 SHALL have parameter SAMPLE_BITS, default 6: width of signed I/Q input samples.
REQ-002 SHALL have parameter LEAD, default 8: PA warm-up length and delay-line depth, in sample strobes, minimum 1.
REQ-003 SHALL have parameter TAIL, default 8: PA hold-off after burst end, in sample strobes, minimum 1.
REQ-004 Port clock: input, 1 bit, sole clock; all logic on its rising edge.
REQ-005 Port reset: input, 1 bit, asynchronous, active-low reset.
REQ-006 Port sample_strobe: input, 1 bit, qualifies a new input sample on this clock.
REQ-007 Port in_inphase: input, SAMPLE_BITS bits, signed I sample from the burst stage.
REQ-008 Port in_quadrature: input, SAMPLE_BITS bits, signed Q sample.
REQ-009 Port iq_valid: input, 1 bit, high when in_inphase/in_quadrature carry burst samples.
REQ-010 Port dac_i: output, 1 bit, registered 1-bit sigma-delta I stream.
REQ-011 Port dac_q: output, 1 bit, registered 1-bit sigma-delta Q stream.
REQ-012 Port pa_enable: output, 1 bit, registered RF PA enable.
REQ-013 Port tx_active: output, 1 bit, registered; high whenever FSM is not IDLE.

Function
REQ-014 Delay line: LEAD entries of {valid, I, Q}; SHALL shift in {iq_valid, in_inphase, in_quadrature} only on clocks with sample_strobe=1, else hold.
REQ-015 Delayed tap (d_valid, d_i, d_q) SHALL be the entry captured LEAD strobes earlier.
REQ-016 FSM states: IDLE, WARMUP, ACTIVE, TAIL; strobe counter counts sample_strobe events only.
REQ-017 IDLE -> WARMUP on clock with sample_strobe=1 and iq_valid=1; pa_enable and tx_active SHALL go high on the next clock.
REQ-018 WARMUP -> ACTIVE when d_valid=1 (exactly LEAD strobes after entry); no sample discarded.
REQ-019 ACTIVE -> TAIL on strobe with d_valid=0; counter cleared.
REQ-020 TAIL -> ACTIVE on strobe with d_valid=1 (PA never drops between bursts).
REQ-021 TAIL -> IDLE after TAIL strobes only if no delay-line entry has valid=1; otherwise SHALL stay in TAIL until d_valid=1.
REQ-022 pa_enable SHALL be high in WARMUP, ACTIVE, TAIL; low in IDLE.
REQ-023 Modulator input x per channel: d_i (d_q) when state=ACTIVE and d_valid=1, else 0.
REQ-024 Accumulator per channel: signed SAMPLE_BITS+2 bits; b = (acc >= 0); acc <= acc + x - (b ? FS : -FS), FS = 2^(SAMPLE_BITS-1); dac_i/dac_q <= b.
REQ-025 Modulator SHALL update every clock (not only on strobes), using held tap values.
REQ-026 In IDLE, accumulators SHALL be held at 0 and dac_i=dac_q=0.
REQ-027 Arithmetic SHALL never overflow for any x in [-FS, FS-1] (plus dither per REQ-031).

Reset
REQ-028 reset=0 SHALL immediately force: state IDLE, pa_enable=0, tx_active=0, dac_i=0, dac_q=0, accumulators=0, all delay-line entries 0, counter 0.
REQ-029 Reset assertion mid-burst SHALL drop pa_enable without waiting for TAIL; after release block SHALL start in IDLE.

Configuration
REQ-030 Macro IQ_SD_DITHER_EN SHALL compile in dither.
REQ-031 With IQ_SD_DITHER_EN: 8-bit Galois LFSR, taps 8'h2d, reset seed 8'h01, advances every clock outside IDLE; x_i += lfsr[0] ? +1 : -1, x_q += lfsr[1] ? +1 : -1 when not in IDLE.
REQ-032 Without IQ_SD_DITHER_EN: no LFSR logic; x used unmodified.

Verification
REQ-033 Dither off, strobe every clock, LEAD=8, TAIL=8, 20 samples I=+16 Q=-16 -> pa_enable rises 1 clock after first valid strobe; ACTIVE 8 strobes later; dac_i 75% ones, dac_q 25% ones over 64 ACTIVE clocks.
REQ-034 WARMUP with x=0 from acc=0 -> dac_i sequence 1,0,1,0,...; ACTIVE with I=-32 -> dac_i all 0 after first bit; I=+31 -> 63 ones per 64 clocks.
REQ-035 Two 10-sample bursts separated by 3 invalid strobes -> pa_enable stays high throughout, no IDLE visit; IDLE reached 8 strobes after second burst's last delayed sample.
REQ-036 sample_strobe every 5 clocks -> first delayed valid sample reaches modulator 40 clocks after pa_enable rise; tap constant between strobes.
REQ-037 reset asserted mid-ACTIVE -> pa_enable, tx_active, dac_i, dac_q all 0 before next clock edge; after release, iq_valid=0 keeps block in IDLE.
REQ-038 Dither on, x=0 -> dac_i pattern deviates from strict alternation; lfsr returns to 8'h01 after each reset.

Source files
------------

// File: rtl/iq_sigma_delta_tx.sv
// -----------------------------------------------------------------------------
// iq_sigma_delta_tx
//   Burst transmitter back end: delays the I/Q burst samples through a LEAD-deep
//   strobe-driven delay line so that the RF power amplifier can warm up before
//   the first sample reaches the DAC. It then converts each channel to a 1-bit
//   first-order sigma-delta stream. After the burst the PA is held on for a
//   TAIL-strobe hold-off.
//
// Parameters
//   SAMPLE_BITS  width of the signed I/Q input samples
//   LEAD         PA warm-up length and delay-line depth, in strobes (>= 1)
//   TAIL         PA hold-off after the burst, in strobes (>= 1)
//
// Ports
//   clock          sole clock, rising edge
//   reset          asynchronous, active-low
//   sample_strobe  qualifies a new input sample on this clock
//   in_inphase     signed I sample
//   in_quadrature  signed Q sample
//   iq_valid       the I/Q inputs carry burst samples
//   dac_i / dac_q  registered 1-bit sigma-delta streams
//   pa_enable      registered RF PA enable
//   tx_active      registered, high whenever the controller is not idle
//
// Configuration
//   IQ_SD_DITHER_EN  when defined, adds +/-1 LSB dither from an 8-bit Galois
//                    LFSR (mask 8'h2d, seed 8'h01) to both modulator inputs
// -----------------------------------------------------------------------------
module iq_sigma_delta_tx #(
  parameter int SAMPLE_BITS = 6,
  parameter int LEAD        = 8,
  parameter int TAIL        = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          sample_strobe,
  input  logic signed [SAMPLE_BITS-1:0] in_inphase,
  input  logic signed [SAMPLE_BITS-1:0] in_quadrature,
  input  logic                          iq_valid,
  output logic                          dac_i,
  output logic                          dac_q,
  output logic                          pa_enable,
  output logic                          tx_active
);

  // Two guard bits keep acc + x -/+ FS inside range for |x| <= FS + 1.
  localparam int ACC_W = SAMPLE_BITS + 2;
  localparam int CNT_W = $clog2(TAIL + 1);
  localparam logic signed [ACC_W-1:0] FS = ACC_W'(2 ** (SAMPLE_BITS - 1));

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_ACTIVE, S_TAIL} state_t;

  // Delay line, r_dl_*[0] newest; r_d_* is the tap holding the entry that left
  // the line on the latest strobe, i.e. the sample captured LEAD strobes ago.
  logic [LEAD-1:0]               r_dl_v;
  logic signed [SAMPLE_BITS-1:0] r_dl_i [LEAD];
  logic signed [SAMPLE_BITS-1:0] r_dl_q [LEAD];
  logic                          r_d_valid;
  logic signed [SAMPLE_BITS-1:0] r_d_i;
  logic signed [SAMPLE_BITS-1:0] r_d_q;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pa_enable;
  logic               r_tx_active;

  logic signed [ACC_W-1:0] r_acc_i;
  logic signed [ACC_W-1:0] r_acc_q;
  logic                    r_dac_i;
  logic                    r_dac_q;

  logic                    w_shift_v;
  logic                    w_pending;
  logic                    w_tail_done;
  logic signed [ACC_W-1:0] w_x_i;
  logic signed [ACC_W-1:0] w_x_q;
  logic                    w_b_i;
  logic                    w_b_q;

  // The FSM decides on the entry about to become the tap, so state and tap
  // change on the same edge and the first delayed sample is never lost.
  assign w_shift_v   = r_dl_v[LEAD-1];
  // Valid samples still in flight, including one arriving on this strobe.
  assign w_pending   = (|r_dl_v) | iq_valid;
  // r_cnt is cleared on the first invalid tap strobe, so r_cnt + 2 is the
  // number of strobes since the last valid delayed sample after this one.
  assign w_tail_done = (int'(r_cnt) + 2 >= TAIL);

  // NOTE: the delay line is a small register file, not RAM, so every entry is
  // reset; a stale valid bit would otherwise start a phantom burst.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dl_v    <= '0;
      for (int k = 0; k < LEAD; k++) begin
        r_dl_i[k] <= '0;
        r_dl_q[k] <= '0;
      end
      r_d_valid <= 1'b0;
      r_d_i     <= '0;
      r_d_q     <= '0;
    end else if (sample_strobe) begin
      // NOTE: non-blocking assignments make every stage read the old value of
      // its neighbour, so the loop order does not matter.
      r_d_valid <= r_dl_v[LEAD-1];
      r_d_i     <= r_dl_i[LEAD-1];
      r_d_q     <= r_dl_q[LEAD-1];
      for (int k = LEAD - 1; k > 0; k--) begin
        r_dl_v[k] <= r_dl_v[k-1];
        r_dl_i[k] <= r_dl_i[k-1];
        r_dl_q[k] <= r_dl_q[k-1];
      end
      r_dl_v[0] <= iq_valid;
      r_dl_i[0] <= in_inphase;
      r_dl_q[0] <= in_quadrature;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pa_enable <= 1'b0;
      r_tx_active <= 1'b0;
    end else if (sample_strobe) begin
      unique case (r_state)
        S_IDLE: begin
          if (iq_valid) begin
            r_state     <= S_WARMUP;
            r_pa_enable <= 1'b1;
            r_tx_active <= 1'b1;
          end
        end
        S_WARMUP: begin
          if (w_shift_v) r_state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (!w_shift_v) begin
            r_state <= S_TAIL;
            r_cnt   <= '0;
          end
        end
        S_TAIL: begin
          if (w_shift_v) begin
            r_state <= S_ACTIVE;
          end else begin
            // Hold the PA while any sample is still travelling the line.
            if (w_tail_done && !w_pending) begin
              r_state     <= S_IDLE;
              r_pa_enable <= 1'b0;
              r_tx_active <= 1'b0;
            end
            if (int'(r_cnt) < TAIL) r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef IQ_SD_DITHER_EN
  localparam logic signed [ACC_W-1:0] DITHER_STEP = ACC_W'(1);
  logic [7:0] r_lfsr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lfsr <= 8'h01;
    end else if (r_state != S_IDLE) begin
      r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ 8'h2d) : (r_lfsr >> 1);
    end
  end
`endif

  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    w_x_i = '0;
    w_x_q = '0;
    if (r_state == S_ACTIVE && r_d_valid) begin
      w_x_i = ACC_W'(r_d_i);
      w_x_q = ACC_W'(r_d_q);
    end
`ifdef IQ_SD_DITHER_EN
    // Only matters outside IDLE: the IDLE branch below ignores w_x_*.
    w_x_i = w_x_i + (r_lfsr[0] ? DITHER_STEP : -DITHER_STEP);
    w_x_q = w_x_q + (r_lfsr[1] ? DITHER_STEP : -DITHER_STEP);
`endif
  end

  assign w_b_i = ~r_acc_i[ACC_W-1];
  assign w_b_q = ~r_acc_q[ACC_W-1];

  // The modulator runs every clock on the held tap value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc_i <= '0;
      r_acc_q <= '0;
      r_dac_i <= 1'b0;
      r_dac_q <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_acc_i <= '0;
      r_acc_q <= '0;
      r_dac_i <= 1'b0;
      r_dac_q <= 1'b0;
    end else begin
      r_acc_i <= r_acc_i + w_x_i - (w_b_i ? FS : -FS);
      r_acc_q <= r_acc_q + w_x_q - (w_b_q ? FS : -FS);
      r_dac_i <= w_b_i;
      r_dac_q <= w_b_q;
    end
  end

  assign dac_i     = r_dac_i;
  assign dac_q     = r_dac_q;
  assign pa_enable = r_pa_enable;
  assign tx_active = r_tx_active;

endmodule
